// File: rtl/lfsr_pkg.sv
// Shared helpers for the Fibonacci/Galois LFSR equivalence checker.
package lfsr_pkg;

  function automatic int idxW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_LN    = 8;
  localparam int DEF_IDX_W = idxW(DEF_LN);

  function automatic logic parity(input logic [31:0] v);
    return ^v;
  endfunction

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++)
      c = c + 6'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// W-step combinational LFSR advance, Fibonacci or Galois form.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int          LN     = 8,
  parameter int unsigned TAPS   = 45,
  parameter int          W      = 1,
  parameter bit          GALOIS = 1'b0
) (
  input  logic [LN-1:0] state,
  input  logic [W-1:0]  bits,
  output logic [LN-1:0] nextState,
  output logic [W-1:0]  yBits
);

  localparam logic [LN-1:0] TAP_M = LN'(TAPS);

  logic [LN-1:0] s;
  logic          yb;

  always_comb begin
    s     = state;
    yb    = 1'b0;
    yBits = '0;
    for (int i = 0; i < W; i++) begin
      if (GALOIS) begin
        yb = bits[i] ^ s[LN-1];
        s  = {s[LN-2:0], 1'b0} ^ (yb ? TAP_M : '0);
      end else begin
        yb = bits[i] ^ parity(32'(s & TAP_M));
        s  = {yb, s[LN-1:1]};
      end
      yBits[i] = yb;
    end
    nextState = s;
  end

endmodule

// File: rtl/lfsr_equiv_checker.sv
// Runs Fibonacci and Galois LFSRs in lockstep and counts output mismatches.
module lfsr_equiv_checker
  import lfsr_pkg::*;
#(
  parameter int          LN          = 8,
  parameter int unsigned TAPS        = 45,
  parameter int          W           = 1,
  parameter int          CW          = 16,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  shiftBits__ENA,
  input  logic [W-1:0]          shiftBits_v,
  output logic                  shiftBits__RDY,
  input  logic                  clear__ENA,
  output logic                  clear__RDY,
  input  logic                  inject__ENA,
  input  logic [idxW(LN)-1:0]   inject_v,
  output logic                  inject__RDY,
  output logic [W-1:0]          outBits,
  output logic                  outBits__RDY,
  output logic                  errFlag,
  output logic [CW-1:0]         errCount,
  output logic [31:0]           stepCount,
  output logic [31:0]           firstErrStep
);

  logic [LN-1:0]  fib, gal, galPre, fibNext, galNext, flipMask;
  logic [W-1:0]   yFib, yGal, mismatch, outReg;
  logic           beatOk, injOk, outRdyReg, errReg;
  logic [CW-1:0]  errCnt, errSat;
  logic [CW+5:0]  errSum;
  logic [31:0]    steps, firstErr;

  assign shiftBits__RDY = !(STOP_ON_ERR && errReg);
  assign clear__RDY     = 1'b1;
  assign inject__RDY    = 1'b1;

  assign beatOk   = shiftBits__ENA && shiftBits__RDY;
  assign injOk    = inject__ENA && (int'(inject_v) < LN);
  assign flipMask = injOk ? (LN'(1) << inject_v) : '0;
  // The fault lands before this cycle's steps so it shows in the same beat.
  assign galPre   = gal ^ flipMask;

  lfsr_step #(.LN(LN), .TAPS(TAPS), .W(W), .GALOIS(1'b0)) uFib (
    .state(fib), .bits(shiftBits_v),
    .nextState(fibNext), .yBits(yFib)
  );

  lfsr_step #(.LN(LN), .TAPS(TAPS), .W(W), .GALOIS(1'b1)) uGal (
    .state(galPre), .bits(shiftBits_v),
    .nextState(galNext), .yBits(yGal)
  );

  assign mismatch = yFib ^ yGal;
  assign errSum   = (CW+6)'(errCnt)
                  + (CW+6)'(popcount(32'(mismatch)));
  assign errSat   = (errSum > (CW+6)'({CW{1'b1}}))
                  ? {CW{1'b1}} : errSum[CW-1:0];

  always_ff @(posedge CLK) begin
    if (RST || clear__ENA) begin
      fib       <= '0;
      gal       <= '0;
      outReg    <= '0;
      outRdyReg <= 1'b0;
      errReg    <= 1'b0;
      errCnt    <= '0;
      steps     <= '0;
      firstErr  <= '0;
    end else begin
      gal <= beatOk ? galNext : galPre;
      if (beatOk) begin
        fib       <= fibNext;
        outReg    <= yFib;
        outRdyReg <= 1'b1;
        errCnt    <= errSat;
        steps     <= steps + 32'd1;
        if (|mismatch && !errReg) begin
          errReg   <= 1'b1;
          firstErr <= steps;
        end
      end
    end
  end

  assign outBits      = outReg;
  assign outBits__RDY = outRdyReg;
  assign errFlag      = errReg;
  assign errCount     = errCnt;
  assign stepCount    = steps;
  assign firstErrStep = firstErr;

endmodule
